display_pos_to_map_addr: RTL
============================

// Module: display_pos_to_map_addr
// PURPOSE
//  Parametrised successor of the display-position-to-map-index mapper. Converts a raster
//  pixel position into tile indices, an in-tile pixel offset and the linear tile-map RAM
//  address (idx_y*MAP_W + idx_x). The address is built with a row-base tracker, not a
//  multiplier; sits between the VGA timing generator and the tile-map RAM read port.
// PARAMETERS
//  H_W         11   horizontal position width
//  V_W         10   vertical position width
//  TILE_SHIFT  4    log2 of tile edge in pixels (16x16)
//  MAP_W       80   map width in tiles
//  MAP_H       50   map height in tiles
//  IDX_X_W     7    matrix_idx_x width; must hold MAP_W-1
//  IDX_Y_W     6    matrix_idx_y width; must hold MAP_H-1
//  ADDR_W      12   map_addr width; must hold MAP_W*MAP_H-1
//  H_START     0    first visible horizontal pixel
//  V_START     0    first visible vertical pixel
//  CENTER_OFF  7    tile-centre correction subtracted before the shift
// PORTS
//  clk           in   1           clock
//  rst           in   1           synchronous reset, active-high
//  pos_valid     in   1           position valid; accepted when pos_valid & in_ready
//  display_pos_x in   H_W         raster x
//  display_pos_y in   V_W         raster y
//  in_ready      out  1           block can accept a position this cycle
//  out_valid     out  1           one-cycle result strobe (no backpressure)
//  matrix_idx_x  out  IDX_X_W     tile column
//  matrix_idx_y  out  IDX_Y_W     tile row
//  tile_off_x    out  TILE_SHIFT  pixel offset inside tile, x
//  tile_off_y    out  TILE_SHIFT  pixel offset inside tile, y
//  map_addr      out  ADDR_W      linear map address; 0 when in_map=0
//  in_map        out  1           position lies inside the MAP_W x MAP_H map
// BEHAVIOUR
//  - Reset: all outputs 0 except in_ready=1; row_base=0, row_y=0, FSM=TRACK, stage regs invalid.
//  - S0 (accept cycle N): rel = pos - START - CENTER_OFF in H_W+1 / V_W+1 bits; borrow => out of map.
//    idx = rel >> TILE_SHIFT; off = rel[TILE_SHIFT-1:0]; in_map = no borrow & idx_x<MAP_W & idx_y<MAP_H.
//    Registered at end of N.
//  - S1 row tracker, FSM {TRACK, RESYNC}, in TRACK:
//    in_map=0      : result at N+2, map_addr=0, idx/off still driven (truncated), tracker unchanged.
//    idx_y==row_y  : hit; map_addr=row_base+idx_x at N+2.
//    idx_y==row_y+1: step; row_base+=MAP_W, row_y++; map_addr from new base at N+2.
//    idx_y==0      : clear; row_base=0, row_y=0; result at N+2.
//    otherwise     : enter RESYNC; row_base=0, cnt=0; in_ready=0 from N+1.
//  - RESYNC: each cycle row_base+=MAP_W, cnt++; when cnt==idx_y go TRACK, row_y=idx_y,
//    out_valid next cycle. Total extra latency = idx_y cycles. in_ready returns to 1 in the
//    cycle out_valid is asserted.
//  - in_ready=0 only in RESYNC or the cycle RESYNC is entered; pos_valid then is ignored (not queued).
//  - Hit/step/clear sustain one accepted position per clock, 2-cycle latency, fully pipelined.
//  - Idx truncation: out-of-map idx is rel>>TILE_SHIFT truncated to IDX_*_W; consumers gate on in_map.
//  - Simultaneous accept in N+1 while S1 enters RESYNC cannot occur (in_ready already 0).
//  - rst mid-RESYNC: next cycle FSM=TRACK, in_ready=1, out_valid=0, pending result discarded.
//  - map_addr arithmetic is unsigned ADDR_W; row_base never exceeds (MAP_H-1)*MAP_W.
// TESTING
//  1 Reset: hold rst 2 cycles -> out_valid=0, map_addr=0, in_map=0, in_ready=1.
//  2 pos (7,7) accepted at N -> N+2: idx (0,0), off (0,0), map_addr 0, in_map 1.
//  3 Raster y=23, x=7..1286 every cycle -> first result is step (row_y 0->1);
//    x=1286 gives idx_x 79, map_addr 159; in_ready stays 1, one result per clock.
//  4 From row 1, pos (7,167) -> idx_y 10, in_ready low 11 cycles, map_addr 800; next (23,167) is a hit, addr 801, latency 2.
//  5 pos (3,7) -> in_map 0, map_addr 0; pos (1287,7) -> idx_x 80, in_map 0; row_y unchanged.
//  6 Assert rst 1 cycle during RESYNC of test 4 -> no out_valid, in_ready 1, then pos (7,23) is a step, addr 80.

Source files
------------

// File: rtl/display_pos_to_map_addr.sv
// display_pos_to_map_addr
//   Maps a raster pixel position to tile indices, an in-tile pixel offset and the
//   linear tile-map RAM address (idx_y*MAP_W + idx_x). Instead of a multiplier, the
//   address comes from a row-base tracker that follows the raster row by row. When
//   the position jumps to an unrelated row, the tracker re-walks from row 0, and
//   input is stalled while it does so.
// Ports
//   clk, rst        clock, synchronous active-high reset
//   pos_valid       position valid; accepted when pos_valid & in_ready
//   display_pos_x/y raster position
//   in_ready        block can accept a position this cycle
//   out_valid       one-cycle result strobe (no backpressure)
//   matrix_idx_x/y  tile column / row (truncated when out of map)
//   tile_off_x/y    pixel offset inside the tile
//   map_addr        linear map address, 0 when in_map=0
//   in_map          position lies inside the MAP_W x MAP_H map
module display_pos_to_map_addr #(
  parameter int unsigned H_W        = 11,
  parameter int unsigned V_W        = 10,
  parameter int unsigned TILE_SHIFT = 4,
  parameter int unsigned MAP_W      = 80,
  parameter int unsigned MAP_H      = 50,
  parameter int unsigned IDX_X_W    = 7,
  parameter int unsigned IDX_Y_W    = 6,
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned H_START    = 0,
  parameter int unsigned V_START    = 0,
  parameter int unsigned CENTER_OFF = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pos_valid,
  input  logic [H_W-1:0]        display_pos_x,
  input  logic [V_W-1:0]        display_pos_y,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [IDX_X_W-1:0]    matrix_idx_x,
  output logic [IDX_Y_W-1:0]    matrix_idx_y,
  output logic [TILE_SHIFT-1:0] tile_off_x,
  output logic [TILE_SHIFT-1:0] tile_off_y,
  output logic [ADDR_W-1:0]     map_addr,
  output logic                  in_map
);

  typedef enum logic {TRACK, RESYNC} state_t;

  localparam logic [H_W:0]     X_SUB     = (H_W+1)'(H_START + CENTER_OFF);
  localparam logic [V_W:0]     Y_SUB     = (V_W+1)'(V_START + CENTER_OFF);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(MAP_W);
  localparam logic [IDX_Y_W:0] ONE_Y     = (IDX_Y_W+1)'(1);

  // Stage 0: offset-corrected position; the extra top bit is the borrow.
  logic [H_W:0]              rel_x;
  logic [V_W:0]              rel_y;
  logic [H_W-TILE_SHIFT-1:0] q_x;
  logic [V_W-TILE_SHIFT-1:0] q_y;
  logic                      pos_in_map;
  logic                      accept;

  assign rel_x      = {1'b0, display_pos_x} - X_SUB;
  assign rel_y      = {1'b0, display_pos_y} - Y_SUB;
  assign q_x        = rel_x[H_W-1:TILE_SHIFT];
  assign q_y        = rel_y[V_W-1:TILE_SHIFT];
  assign pos_in_map = !rel_x[H_W] && !rel_y[V_W] &&
                      (32'(q_x) < MAP_W) && (32'(q_y) < MAP_H);
  assign accept     = pos_valid && in_ready;

  logic                  s0_valid;
  logic [IDX_X_W-1:0]    s0_idx_x;
  logic [IDX_Y_W-1:0]    s0_idx_y;
  logic [TILE_SHIFT-1:0] s0_off_x;
  logic [TILE_SHIFT-1:0] s0_off_y;
  logic                  s0_in_map;

  // Stage 0 data loads only on accept, so it stays put for the whole RESYNC walk.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid  <= 1'b0;
      s0_idx_x  <= '0;
      s0_idx_y  <= '0;
      s0_off_x  <= '0;
      s0_off_y  <= '0;
      s0_in_map <= 1'b0;
    end else begin
      s0_valid <= accept;
      if (accept) begin
        s0_idx_x  <= IDX_X_W'(q_x);
        s0_idx_y  <= IDX_Y_W'(q_y);
        s0_off_x  <= rel_x[TILE_SHIFT-1:0];
        s0_off_y  <= rel_y[TILE_SHIFT-1:0];
        s0_in_map <= pos_in_map;
      end
    end
  end

  // Stage 1: row-base tracker.
  state_t              state, state_nx;
  logic [ADDR_W-1:0]   row_base, row_base_nx, step_base, col;
  logic [IDX_Y_W-1:0]  row_y, row_y_nx, cnt, cnt_nx;
  logic                hit, step, clear, miss;
  logic                res_valid;
  logic [ADDR_W-1:0]   res_addr;

  assign step_base = row_base + ROW_STEP;
  assign col       = ADDR_W'(s0_idx_x);
  assign hit       = (s0_idx_y == row_y);
  assign step      = ({1'b0, s0_idx_y} == ({1'b0, row_y} + ONE_Y));
  assign clear     = (s0_idx_y == '0);
  assign miss      = (state == TRACK) && s0_valid && s0_in_map && !(hit || step || clear);
  // Drops combinationally in the cycle the miss is seen, before RESYNC is registered.
  assign in_ready  = (state == TRACK) && !miss;

  always_comb begin
    state_nx    = state;
    row_base_nx = row_base;
    row_y_nx    = row_y;
    cnt_nx      = cnt;
    res_valid   = 1'b0;
    res_addr    = '0;
    case (state)
      TRACK: begin
        if (s0_valid) begin
          if (!s0_in_map) begin
            res_valid = 1'b1;
          end else if (hit) begin
            res_valid = 1'b1;
            res_addr  = row_base + col;
          end else if (step) begin
            row_base_nx = step_base;
            row_y_nx    = row_y + 1'b1;
            res_valid   = 1'b1;
            res_addr    = step_base + col;
          end else if (clear) begin
            row_base_nx = '0;
            row_y_nx    = '0;
            res_valid   = 1'b1;
            res_addr    = col;
          end else begin
            state_nx    = RESYNC;
            row_base_nx = '0;
            cnt_nx      = '0;
          end
        end
      end
      RESYNC: begin
        row_base_nx = step_base;
        cnt_nx      = cnt + 1'b1;
        if (cnt_nx == s0_idx_y) begin
          state_nx  = TRACK;
          row_y_nx  = s0_idx_y;
          res_valid = 1'b1;
          res_addr  = step_base + col;
        end
      end
      default: state_nx = TRACK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= TRACK;
      row_base     <= '0;
      row_y        <= '0;
      cnt          <= '0;
      out_valid    <= 1'b0;
      matrix_idx_x <= '0;
      matrix_idx_y <= '0;
      tile_off_x   <= '0;
      tile_off_y   <= '0;
      map_addr     <= '0;
      in_map       <= 1'b0;
    end else begin
      state     <= state_nx;
      row_base  <= row_base_nx;
      row_y     <= row_y_nx;
      cnt       <= cnt_nx;
      out_valid <= res_valid;
      if (res_valid) begin
        matrix_idx_x <= s0_idx_x;
        matrix_idx_y <= s0_idx_y;
        tile_off_x   <= s0_off_x;
        tile_off_y   <= s0_off_y;
        map_addr     <= res_addr;
        in_map       <= s0_in_map;
      end
    end
  end

endmodule
